// File: rtl/defuzzificador_t2.sv
// Nie-Tan type-reduction and defuzzification of 3 type-2 rules: y = sum(w_i*C_i)/sum(w_i), w_i = UP_i+LOW_i.
// Latency: accept edge T -> valid_out at T+23 (T+4 when no rule contributes weight).
// Backpressure: one set in flight; ready_in low outside IDLE, result held in DONE until ready_out.
module defuzzificador_t2 #(
    parameter logic [7:0] C1           = 8'd0,
    parameter logic [7:0] C2           = 8'd128,
    parameter logic [7:0] C3           = 8'd255,
    parameter logic [7:0] SAIDA_PADRAO = 8'd128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic [31:0] MF_01_UP,
    input  logic [31:0] MF_01_LOW,
    input  logic [31:0] MF_02_UP,
    input  logic [31:0] MF_02_LOW,
    input  logic [31:0] MF_03_UP,
    input  logic [31:0] MF_03_LOW,
    input  logic        Ativo_1,
    input  logic        Ativo_2,
    input  logic        Ativo_3,
    output logic [7:0]  saida,
    output logic        sem_regra,
    output logic        valid_out,
    input  logic        ready_out
);

    typedef enum logic [1:0] {IDLE, ACC, DIV, DONE} state_t;

    state_t      state, state_n;
    logic [7:0]  up_r  [0:2];
    logic [7:0]  low_r [0:2];
    logic [2:0]  ativo_r;        // bit 0 = rule 1
    logic [1:0]  idx;
    logic [18:0] num;            // numerator, then reused as the quotient shift register
    logic [10:0] den;
    logic [11:0] rem;
    logic [4:0]  cnt;

    logic        accept;
    logic [8:0]  w_cur;
    logic [7:0]  c_cur;
    logic [18:0] prod;
    logic [10:0] den_add;
    logic [12:0] r_sh;
    logic        r_ge;
    logic [11:0] r_sub;

    // Degrees above 255 clip to full membership.
    function automatic logic [7:0] sat8(input logic [31:0] v);
        return (|v[31:8]) ? 8'hFF : v[7:0];
    endfunction

    assign accept = valid_in && ready_in && (state == IDLE);

    // Weight and centroid of the rule selected by idx; disabled rules weigh zero.
    always_comb begin
        w_cur = 9'd0;
        c_cur = 8'd0;
        case (idx)
            2'd0: begin
                c_cur = C1;
                if (ativo_r[0]) w_cur = {1'b0, up_r[0]} + {1'b0, low_r[0]};
            end
            2'd1: begin
                c_cur = C2;
                if (ativo_r[1]) w_cur = {1'b0, up_r[1]} + {1'b0, low_r[1]};
            end
            default: begin
                c_cur = C3;
                if (ativo_r[2]) w_cur = {1'b0, up_r[2]} + {1'b0, low_r[2]};
            end
        endcase
    end

    assign prod    = {10'd0, w_cur} * {11'd0, c_cur};
    assign den_add = den + {2'd0, w_cur};

    // One restoring step: shift in the next numerator bit, subtract if it fits.
    // The difference is below den, so 12 bits of it are enough.
    assign r_sh  = {rem, num[18]};
    assign r_ge  = (r_sh >= {2'b0, den});
    assign r_sub = r_sh[11:0] - {1'b0, den};

    // Next-state decode.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = ACC;
            ACC:  if (idx == 2'd2) state_n = DIV;
            DIV:  if ((cnt == 5'd0 && den == 11'd0) || cnt == 5'd19) state_n = DONE;
            DONE: if (ready_out) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register; ready_in is registered so it stays low through the reset cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ready_in <= 1'b0;
        end else begin
            state    <= state_n;
            ready_in <= (state_n == IDLE);
        end
    end

    // Datapath: capture, serial accumulate, divide, hold result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                up_r[k]  <= 8'd0;
                low_r[k] <= 8'd0;
            end
            ativo_r   <= 3'd0;
            idx       <= 2'd0;
            num       <= 19'd0;
            den       <= 11'd0;
            rem       <= 12'd0;
            cnt       <= 5'd0;
            saida     <= 8'd0;
            sem_regra <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    up_r[0]  <= sat8(MF_01_UP);
                    low_r[0] <= sat8(MF_01_LOW);
                    up_r[1]  <= sat8(MF_02_UP);
                    low_r[1] <= sat8(MF_02_LOW);
                    up_r[2]  <= sat8(MF_03_UP);
                    low_r[2] <= sat8(MF_03_LOW);
                    ativo_r  <= {Ativo_3, Ativo_2, Ativo_1};
                    idx      <= 2'd0;
                    num      <= 19'd0;
                    den      <= 11'd0;
                    rem      <= 12'd0;
                    cnt      <= 5'd0;
                end
                ACC: begin
                    num <= num + prod;
                    den <= den_add;
                    idx <= idx + 2'd1;
                end
                DIV: begin
                    if (cnt == 5'd0 && den == 11'd0) begin
                        saida     <= SAIDA_PADRAO;
                        sem_regra <= 1'b1;
                        valid_out <= 1'b1;
                    end else if (cnt == 5'd19) begin
                        saida     <= num[7:0];
                        sem_regra <= 1'b0;
                        valid_out <= 1'b1;
                    end else begin
                        rem <= r_ge ? r_sub : r_sh[11:0];
                        num <= {num[17:0], r_ge};
                        cnt <= cnt + 5'd1;
                    end
                end
                DONE: if (ready_out) valid_out <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_defuzzificador_t2.sv
// Bench for defuzzificador_t2: directed sets, expected results queued at accept time.
// A monitor compares every new result (value, no-rule flag, latency) with the queue head.
// Reset, backpressure and mid-operation abort are checked directly by the stimulus.
module tb_defuzzificador_t2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        ready_in;
    logic [31:0] MF_01_UP, MF_01_LOW, MF_02_UP, MF_02_LOW, MF_03_UP, MF_03_LOW;
    logic        Ativo_1, Ativo_2, Ativo_3;
    logic [7:0]  saida;
    logic        sem_regra;
    logic        valid_out;
    logic        ready_out;

    typedef struct {
        logic [7:0] s;
        logic       sr;
        int         lat;
        int         t;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   t_acc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    defuzzificador_t2 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .MF_01_UP  (MF_01_UP),
        .MF_01_LOW (MF_01_LOW),
        .MF_02_UP  (MF_02_UP),
        .MF_02_LOW (MF_02_LOW),
        .MF_03_UP  (MF_03_UP),
        .MF_03_LOW (MF_03_LOW),
        .Ativo_1   (Ativo_1),
        .Ativo_2   (Ativo_2),
        .Ativo_3   (Ativo_3),
        .saida     (saida),
        .sem_regra (sem_regra),
        .valid_out (valid_out),
        .ready_out (ready_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: each rising valid_out is one result; compare against the queue head.
    initial begin
        logic vo_prev;
        exp_t e;
        vo_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (valid_out === 1'b1 && !vo_prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", {24'd0, saida}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("saida", {24'd0, saida}, {24'd0, e.s});
                    chk("sem_regra", {31'd0, sem_regra}, {31'd0, e.sr});
                    chk("latency", cyc - e.t, e.lat);
                end
            end
            vo_prev = (valid_out === 1'b1);
        end
    end

    // Present one set at a negedge, wait for the accept edge, queue the expectation.
    task automatic send(input logic [31:0] u1, input logic [31:0] l1,
                        input logic [31:0] u2, input logic [31:0] l2,
                        input logic [31:0] u3, input logic [31:0] l3,
                        input logic [2:0] a, input logic [7:0] es, input logic esr,
                        input int el, input bit push, output int t);
        int   n;
        exp_t e;
        n = 0;
        while (ready_in !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_in_wait", {31'd0, ready_in}, 32'd1);
        MF_01_UP = u1; MF_01_LOW = l1;
        MF_02_UP = u2; MF_02_LOW = l2;
        MF_03_UP = u3; MF_03_LOW = l3;
        Ativo_1 = a[2]; Ativo_2 = a[1]; Ativo_3 = a[0];
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        t = cyc;
        if (push) begin
            e.s = es; e.sr = esr; e.lat = el; e.t = t;
            sb.push_back(e);
        end
        // Inputs are free to change once the set is captured.
        MF_01_UP = $urandom; MF_01_LOW = $urandom;
        MF_02_UP = $urandom; MF_02_LOW = $urandom;
        MF_03_UP = $urandom; MF_03_LOW = $urandom;
        Ativo_1 = 1'($urandom); Ativo_2 = 1'($urandom); Ativo_3 = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || valid_out !== 1'b0 || ready_in !== 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", {31'd0, (n < 200)}, 32'd1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
        MF_01_UP = '0; MF_01_LOW = '0; MF_02_UP = '0; MF_02_LOW = '0;
        MF_03_UP = '0; MF_03_LOW = '0;
        Ativo_1 = 1'b0; Ativo_2 = 1'b0; Ativo_3 = 1'b0;

        // Reset for two edges.
        repeat (2) @(negedge clk);
        chk("rst_saida", {24'd0, saida}, 32'd0);
        chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
        chk("rst_sem_regra", {31'd0, sem_regra}, 32'd0);
        chk("rst_ready_in", {31'd0, ready_in}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready_in", {31'd0, ready_in}, 32'd1);

        // Rule 1 only, full weight 510 at centroid 0.
        send(255, 255, 0, 0, 0, 0, 3'b100, 8'd0, 1'b0, 23, 1'b1, t_acc);
        drain();
        // Rules 2 and 3: 178946/892 -> 200.
        send(0, 0, 255, 127, 255, 255, 3'b011, 8'd200, 1'b0, 23, 1'b1, t_acc);
        drain();
        // No rule enabled with nonzero degrees -> default, flag set, short path.
        send(10, 20, 30, 40, 50, 60, 3'b000, 8'd128, 1'b1, 4, 1'b1, t_acc);
        drain();
        // Saturated upper degree on rule 2: w=255 -> 128.
        send(0, 0, 32'h1FF, 0, 0, 0, 3'b010, 8'd128, 1'b0, 23, 1'b1, t_acc);
        drain();
        // All three rules, w=100 each: 38300/300 -> 127 (floor).
        send(100, 0, 100, 0, 100, 0, 3'b111, 8'd127, 1'b0, 23, 1'b1, t_acc);
        drain();
        // Rule 3 only, lower degree saturates from high bits: -> 255.
        send(0, 0, 0, 0, 0, 32'h12345, 3'b001, 8'd255, 1'b0, 23, 1'b1, t_acc);
        drain();
        // w1=1, w2=2: 256/3 -> 85.
        send(1, 0, 1, 1, 0, 0, 3'b110, 8'd85, 1'b0, 23, 1'b1, t_acc);
        drain();
        // All enabled but all degrees zero -> default.
        send(0, 0, 0, 0, 0, 0, 3'b111, 8'd128, 1'b1, 4, 1'b1, t_acc);
        drain();

        // Backpressure: hold the result for 10 cycles while offering a new set.
        ready_out = 1'b0;
        send(0, 0, 255, 127, 255, 255, 3'b011, 8'd200, 1'b0, 23, 1'b1, t_acc);
        n = 0;
        while (valid_out !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", {31'd0, valid_out}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            valid_in = (i < 9);
            MF_01_UP = 200; MF_01_LOW = 200; Ativo_1 = 1'b1;
            @(negedge clk);
            chk("bp_valid_out", {31'd0, valid_out}, 32'd1);
            chk("bp_saida", {24'd0, saida}, 32'd200);
            chk("bp_ready_in", {31'd0, ready_in}, 32'd0);
        end
        ready_out = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", {31'd0, valid_out}, 32'd0);
        chk("bp_release_ready", {31'd0, ready_in}, 32'd1);
        chk("bp_saida_kept", {24'd0, saida}, 32'd200);
        drain();

        // Abort: reset sampled at T+10 discards the set in flight.
        send(0, 0, 32'h1FF, 0, 0, 0, 3'b010, 8'd128, 1'b0, 23, 1'b0, t_acc);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_valid_out", {31'd0, valid_out}, 32'd0);
        chk("abort_saida", {24'd0, saida}, 32'd0);
        chk("abort_sem_regra", {31'd0, sem_regra}, 32'd0);
        chk("abort_ready_in", {31'd0, ready_in}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready_after", {31'd0, ready_in}, 32'd1);
        repeat (30) @(negedge clk);
        chk("abort_no_result", {31'd0, valid_out}, 32'd0);
        chk("abort_saida_late", {24'd0, saida}, 32'd0);

        // Normal operation resumes after the abort.
        send(1, 0, 1, 1, 0, 0, 3'b110, 8'd85, 1'b0, 23, 1'b1, t_acc);
        drain();

        chk("queue_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
